// File: rtl/adc_serial_sampler.sv
`default_nettype none
// adc_serial_sampler: periodically triggers a serial ADC, shifts in one MSB-first
// result and publishes it with a one-cycle valid strobe.  Rev 1.0
module adc_serial_sampler #(
   parameter int DATA_BITS     = 12,
   parameter int CFG_BITS      = 6,
   parameter int CLK_DIV       = 2,
   parameter int CONV_HIGH     = 2,
   parameter int CONV_WAIT     = 80,
   parameter int SAMPLE_PERIOD = 256
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 run,
   input  logic [CFG_BITS-1:0]  cfg,
   output logic                 adc_convst,
   output logic                 adc_sclk,
   output logic                 adc_sdi,
   input  logic                 adc_sdo,
   output logic [DATA_BITS-1:0] sample,
   output logic                 sample_valid,
   output logic                 busy,
   output logic                 overrun
);

   localparam int c_max_a = (CONV_HIGH > CONV_WAIT) ? CONV_HIGH : CONV_WAIT;
   localparam int c_max   = (c_max_a > CLK_DIV) ? c_max_a : CLK_DIV;
   localparam int c_cw    = (c_max > 1) ? $clog2(c_max) : 1;
   localparam int c_bw    = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam int c_pw    = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CONV  = 3'd1,
      S_WAIT  = 3'd2,
      S_SHIFT = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t               state_q,  state_d;
   logic [c_pw-1:0]      per_q,    per_d;
   logic [c_cw-1:0]      cnt_q,    cnt_d;
   logic [c_bw-1:0]      bit_q,    bit_d;
   logic [CFG_BITS-1:0]  sdi_sr_q, sdi_sr_d;
   logic [DATA_BITS-1:0] rx_q,     rx_d;
   logic [DATA_BITS-1:0] sample_q, sample_d;
   logic                 convst_q, convst_d;
   logic                 sclk_q,   sclk_d;
   logic                 sdi_q,    sdi_d;
   logic                 valid_q,  valid_d;
   logic                 ovr_q,    ovr_d;
   logic                 w_tick;

   assign w_tick = run && (per_q == '0);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         per_q    <= '0;
         cnt_q    <= '0;
         bit_q    <= '0;
         sdi_sr_q <= '0;
         rx_q     <= '0;
         sample_q <= '0;
         convst_q <= 1'b0;
         sclk_q   <= 1'b0;
         sdi_q    <= 1'b0;
         valid_q  <= 1'b0;
         ovr_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         per_q    <= per_d;
         cnt_q    <= cnt_d;
         bit_q    <= bit_d;
         sdi_sr_q <= sdi_sr_d;
         rx_q     <= rx_d;
         sample_q <= sample_d;
         convst_q <= convst_d;
         sclk_q   <= sclk_d;
         sdi_q    <= sdi_d;
         valid_q  <= valid_d;
         ovr_q    <= ovr_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      per_d    = '0;
      cnt_d    = cnt_q;
      bit_d    = bit_q;
      sdi_sr_d = sdi_sr_q;
      rx_d     = rx_q;
      sample_d = sample_q;
      convst_d = convst_q;
      sclk_d   = sclk_q;
      sdi_d    = sdi_q;
      valid_d  = 1'b0;
      ovr_d    = ovr_q | (w_tick && (state_q != S_IDLE));

      if (run) begin
         per_d = (per_q == c_pw'(SAMPLE_PERIOD - 1)) ? '0 : per_q + 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            if (w_tick) begin
               state_d  = S_CONV;
               convst_d = 1'b1;
               sdi_sr_d = cfg;
               rx_d     = '0;
               cnt_d    = '0;
            end
         end
         S_CONV: begin
            if (cnt_q == c_cw'(CONV_HIGH - 1)) begin
               state_d  = S_WAIT;
               convst_d = 1'b0;
               cnt_d    = '0;
               sdi_d    = sdi_sr_q[CFG_BITS-1];
               sdi_sr_d = sdi_sr_q << 1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_WAIT: begin
            if (cnt_q == c_cw'(CONV_WAIT - 1)) begin
               state_d = S_SHIFT;
               cnt_d   = '0;
               bit_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_SHIFT: begin
            if (cnt_q == c_cw'(CLK_DIV - 1)) begin
               cnt_d = '0;
               if (!sclk_q) begin
                  // The edge that raises SCLK is the one that samples SDO.
                  sclk_d = 1'b1;
                  rx_d   = {rx_q[DATA_BITS-2:0], adc_sdo};
               end else begin
                  sclk_d   = 1'b0;
                  sdi_d    = sdi_sr_q[CFG_BITS-1];
                  sdi_sr_d = sdi_sr_q << 1;
                  if (bit_q == c_bw'(DATA_BITS - 1)) begin
                     state_d = S_DONE;
                  end else begin
                     bit_d = bit_q + 1'b1;
                  end
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DONE: begin
            state_d  = S_IDLE;
            sample_d = rx_q;
            valid_d  = 1'b1;
            sdi_d    = 1'b0;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign adc_convst   = convst_q;
   assign adc_sclk     = sclk_q;
   assign adc_sdi      = sdi_q;
   assign sample       = sample_q;
   assign sample_valid = valid_q;
   assign busy         = (state_q != S_IDLE);
   assign overrun      = ovr_q;

endmodule
`default_nettype wire

// File: tb/tb_adc_serial_sampler.sv
`default_nettype none
// tb_adc_serial_sampler: frame-timeline reference model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_adc_serial_sampler;

   localparam int N  = 12;
   localparam int CB = 6;
   localparam int D  = 2;
   localparam int H  = 2;
   localparam int W  = 80;
   localparam int P0 = 256;
   localparam int P1 = 100;
   localparam int L  = H + W + 2 * D * N + 1;

   logic          clk = 1'b0;
   logic          reset_n;
   logic [1:0]    run_r;
   logic [CB-1:0] cfg_r;

   wire  [1:0]    convst_w, sclk_w, sdi_w, sdo_w, valid_w, busy_w, ovr_w;
   wire  [N-1:0]  sample_w [2];

   logic [1:0]    adc_mode     [2];
   logic [N-1:0]  adc_fix      [2];
   int            adc_seq_base [2];
   wire  [N-1:0]  adc_word_w   [2];
   wire  [N-1:0]  adc_sdi_w    [2];
   wire  [31:0]   adc_bits_w   [2];
   wire  [31:0]   adc_nframe_w [2];

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   adc_serial_sampler #(
      .DATA_BITS(N), .CFG_BITS(CB), .CLK_DIV(D), .CONV_HIGH(H),
      .CONV_WAIT(W), .SAMPLE_PERIOD(P0)
   ) u_dut0 (
      .clk(clk), .reset_n(reset_n), .run(run_r[0]), .cfg(cfg_r),
      .adc_convst(convst_w[0]), .adc_sclk(sclk_w[0]), .adc_sdi(sdi_w[0]),
      .adc_sdo(sdo_w[0]), .sample(sample_w[0]), .sample_valid(valid_w[0]),
      .busy(busy_w[0]), .overrun(ovr_w[0])
   );

   adc_serial_sampler #(
      .DATA_BITS(N), .CFG_BITS(CB), .CLK_DIV(D), .CONV_HIGH(H),
      .CONV_WAIT(W), .SAMPLE_PERIOD(P1)
   ) u_dut1 (
      .clk(clk), .reset_n(reset_n), .run(run_r[1]), .cfg(cfg_r),
      .adc_convst(convst_w[1]), .adc_sclk(sclk_w[1]), .adc_sdi(sdi_w[1]),
      .adc_sdo(sdo_w[1]), .sample(sample_w[1]), .sample_valid(valid_w[1]),
      .busy(busy_w[1]), .overrun(ovr_w[1])
   );

   // ADC models: latch a word on CONVST rise, drive it MSB-first, record SDI on SCLK rise.
   for (genvar g = 0; g < 2; g++) begin : g_adc
      logic [N-1:0] word    = '0;
      logic [N-1:0] sdi_cap = '0;
      int           bits    = 0;
      int           nframe  = 0;
      always @(posedge convst_w[g]) begin
         nframe = nframe + 1;
         case (adc_mode[g])
            2'd0:    word = adc_fix[g];
            2'd1:    word = N'(nframe - adc_seq_base[g]);
            default: word = N'($urandom_range(0, (1 << N) - 1));
         endcase
         bits    = 0;
         sdi_cap = '0;
      end
      always @(posedge sclk_w[g]) begin
         sdi_cap = {sdi_cap[N-2:0], sdi_w[g]};
         bits    = bits + 1;
      end
      assign sdo_w[g]        = (bits < N) ? word[N-1-bits] : 1'b0;
      assign adc_word_w[g]   = word;
      assign adc_sdi_w[g]    = sdi_cap;
      assign adc_bits_w[g]   = bits;
      assign adc_nframe_w[g] = nframe;
   end

   task automatic chk(input string name, input int idx, input logic [31:0] act,
                      input logic [31:0] exp);
      tests = tests + 1;
      if (act !== exp) begin
         fails = fails + 1;
         $display("FAIL %s[%0d] cycle %0d: got 0x%0h, expected 0x%0h",
                  name, idx, cyc, act, exp);
      end
   endtask

   // Reference model: each frame is a timeline indexed by clocks since its start edge.
   int            m_pc     [2];
   int            m_off    [2];
   bit            m_act    [2];
   bit            m_ovr    [2];
   logic [CB-1:0] m_cfg    [2];
   logic [N-1:0]  m_sample [2];
   bit            m_tick, m_busy;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 2; i++) begin
            m_pc[i] = 0; m_off[i] = 0; m_act[i] = 0; m_ovr[i] = 0;
            m_cfg[i] = '0; m_sample[i] = '0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            m_tick = run_r[i] && (m_pc[i] == 0);
            m_busy = m_act[i] && (m_off[i] < L);
            m_pc[i] = run_r[i] ? (m_pc[i] + 1) % ((i == 0) ? P0 : P1) : 0;
            if (m_tick && m_busy) m_ovr[i] = 1;
            if (m_tick && !m_busy) begin
               m_act[i] = 1; m_off[i] = 0; m_cfg[i] = cfg_r;
            end else if (m_act[i]) begin
               m_off[i] = m_off[i] + 1;
               if (m_off[i] == L) m_sample[i] = adc_word_w[i];
               else if (m_off[i] > L) m_act[i] = 0;
            end
         end
      end
   end

   logic         e_cv, e_sk, e_sd, e_bz, e_vl, prev_cv = 1'b0;
   int           e_s, e_j, vcnt1 = 0;
   int           rq[$], fq[$], vcq[$];
   logic [N-1:0] vq[$];

   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         e_s  = m_off[i] - (H + W);
         e_cv = m_act[i] && (m_off[i] < H);
         e_bz = m_act[i] && (m_off[i] < L);
         e_vl = m_act[i] && (m_off[i] == L);
         e_sk = m_act[i] && (e_s >= 0) && (e_s < 2 * D * N) && ((e_s % (2 * D)) >= D);
         e_sd = 1'b0;
         if (m_act[i] && m_off[i] >= H && m_off[i] < L) begin
            e_j = (e_s < 0) ? 0 : e_s / (2 * D);
            if (e_j < CB) e_sd = m_cfg[i][CB-1-e_j];
         end
         chk("adc_convst",   i, 32'(convst_w[i]), 32'(e_cv));
         chk("adc_sclk",     i, 32'(sclk_w[i]),   32'(e_sk));
         chk("adc_sdi",      i, 32'(sdi_w[i]),    32'(e_sd));
         chk("busy",         i, 32'(busy_w[i]),   32'(e_bz));
         chk("sample_valid", i, 32'(valid_w[i]),  32'(e_vl));
         chk("overrun",      i, 32'(ovr_w[i]),    32'(m_ovr[i]));
         chk("sample",       i, 32'(sample_w[i]), 32'(m_sample[i]));
         if (valid_w[i]) chk("sclk_pulses_per_frame", i, adc_bits_w[i], N);
      end
      if (convst_w[0] && !prev_cv) rq.push_back(cyc);
      if (!convst_w[0] && prev_cv) fq.push_back(cyc);
      prev_cv = convst_w[0];
      if (valid_w[0]) begin
         vcq.push_back(cyc);
         vq.push_back(sample_w[0]);
      end
      if (valid_w[1]) vcnt1 = vcnt1 + 1;
   end

   task automatic tick_once(input int i);
      @(posedge clk); #1; run_r[i] = 1'b1;
      @(posedge clk); #1; run_r[i] = 1'b0;
   endtask

   task automatic wait_valid(input int start, input string name);
      int n = 0;
      while (vq.size() == start && n < 400) begin
         @(posedge clk);
         n++;
      end
      #1;
      chk(name, 0, 32'(vq.size() > start), 1);
   endtask

   int nr, nf, nv, n1, n;

   initial begin
      reset_n = 1'b0;
      run_r   = 2'b00;
      cfg_r   = 6'b100010;
      for (int i = 0; i < 2; i++) begin
         adc_mode[i] = 2'd0; adc_fix[i] = '0; adc_seq_base[i] = 0;
      end
      repeat (3) @(posedge clk);
      #1;
      chk("reset_sample",  0, 32'(sample_w[0]), 0);
      chk("reset_busy",    0, 32'(busy_w[0]),   0);
      chk("reset_convst",  0, 32'(convst_w[0]), 0);
      chk("reset_overrun", 0, 32'(ovr_w[0]),    0);
      reset_n = 1'b1;

      // Basic capture and config shift
      adc_fix[0] = 12'hA5C;
      nr = rq.size(); nf = fq.size(); nv = vq.size();
      tick_once(0);
      wait_valid(nv, "basic_valid_seen");
      chk("basic_rises", 0, 32'(rq.size() - nr), 1);
      if (vq.size() > nv && rq.size() > nr && fq.size() > nf) begin
         chk("basic_sample",  0, 32'(vq[nv]), 32'h0A5C);
         chk("basic_latency", 0, 32'(vcq[nv] - rq[nr]), 131);
         chk("convst_width",  0, 32'(fq[nf] - rq[nr]), 2);
      end
      chk("sclk_rises", 0, adc_bits_w[0], 12);
      chk("cfg_sdi_bits", 0, 32'(adc_sdi_w[0]), 32'b100010_000000);
      @(posedge clk); #1;
      chk("busy_after", 0, 32'(busy_w[0]), 0);

      // Periodicity
      adc_mode[0] = 2'd1;
      adc_seq_base[0] = int'(adc_nframe_w[0]);
      nr = rq.size(); nv = vq.size();
      @(posedge clk); #1; run_r[0] = 1'b1;
      repeat (1024) @(posedge clk);
      #1; run_r[0] = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      chk("period_rises",  0, 32'(rq.size() - nr), 4);
      chk("period_valids", 0, 32'(vq.size() - nv), 4);
      if (rq.size() >= nr + 4)
         for (int k = 1; k < 4; k++) chk("rise_spacing", 0, 32'(rq[nr+k] - rq[nr+k-1]), 256);
      if (vq.size() >= nv + 4)
         for (int k = 0; k < 4; k++) chk("period_value", 0, 32'(vq[nv+k]), 32'(k + 1));
      chk("period_overrun", 0, 32'(ovr_w[0]), 0);

      // Randomized run toggling, cfg churn and ADC words
      adc_mode[0] = 2'd2;
      for (int c = 0; c < 3000; c++) begin
         @(posedge clk); #1;
         cfg_r = CB'($urandom);
         if ($urandom_range(0, 149) == 0) run_r[0] = ~run_r[0];
      end
      run_r[0] = 1'b0;
      repeat (200) @(posedge clk);

      // Overrun with a period shorter than a frame
      adc_mode[1] = 2'd2;
      n1 = vcnt1;
      @(posedge clk); #1; run_r[1] = 1'b1;
      repeat (100) @(posedge clk);
      #1;
      chk("overrun_before_2nd_tick", 1, 32'(ovr_w[1]), 0);
      @(posedge clk); #1;
      chk("overrun_after_2nd_tick", 1, 32'(ovr_w[1]), 1);
      repeat (499) @(posedge clk);
      #1; run_r[1] = 1'b0;
      repeat (200) @(posedge clk);
      #1;
      chk("overrun_frames", 1, 32'(vcnt1 - n1), 3);
      chk("overrun_sticky", 1, 32'(ovr_w[1]), 1);

      // Reset in the middle of SHIFT
      adc_mode[0] = 2'd0;
      adc_fix[0]  = 12'h3C9;
      @(posedge clk); #1; run_r[0] = 1'b1;
      n = 0;
      while (adc_bits_w[0] != 5 && n < 400) begin
         @(posedge clk); #1;
         n++;
      end
      chk("reach_bit5", 0, adc_bits_w[0], 5);
      nv = vq.size();
      reset_n  = 1'b0;
      run_r[0] = 1'b0;
      #1;
      chk("midrst_sclk",    0, 32'(sclk_w[0]),   0);
      chk("midrst_convst",  0, 32'(convst_w[0]), 0);
      chk("midrst_sample",  0, 32'(sample_w[0]), 0);
      chk("midrst_busy",    0, 32'(busy_w[0]),   0);
      chk("midrst_valid",   0, 32'(valid_w[0]),  0);
      chk("midrst_overrun", 1, 32'(ovr_w[1]),    0);
      @(posedge clk); @(posedge clk); #1;
      reset_n = 1'b1;
      chk("no_partial_publish", 0, 32'(vq.size() - nv), 0);
      tick_once(0);
      wait_valid(nv, "post_reset_valid_seen");
      chk("post_reset_sample", 0, 32'(sample_w[0]), 32'h03C9);

      // run dropped during WAIT, then all-zero and all-one words
      adc_fix[0] = 12'h000;
      nr = rq.size(); nv = vq.size();
      @(posedge clk); #1; run_r[0] = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      chk("wait_convst_low", 0, 32'(convst_w[0]), 0);
      chk("wait_busy",       0, 32'(busy_w[0]),   1);
      run_r[0] = 1'b0;
      wait_valid(nv, "rundrop_valid_seen");
      chk("zero_sample", 0, 32'(sample_w[0]), 32'h0000);
      repeat (600) @(posedge clk);
      #1;
      chk("no_more_convst", 0, 32'(rq.size() - nr), 1);
      adc_fix[0] = 12'hFFF;
      nv = vq.size();
      tick_once(0);
      wait_valid(nv, "ones_valid_seen");
      chk("ones_sample", 0, 32'(sample_w[0]), 32'h0FFF);

      repeat (5) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog cycle %0d: got no finish, expected finish", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire

// File: doc/adc_serial_sampler.md
Name: adc_serial_sampler

Overview:
- Front-end capture stage for the moving-average filter. Periodically triggers an external serial ADC (CONVST/SCLK/SDI/SDO, MSB-first), shifts in one DATA_BITS-wide conversion result and presents it with a one-cycle valid strobe.
- sample and sample_valid connect directly to the averager's Din and EN inputs.
- Sample rate is set by a free-running period counter, so the averager sees evenly spaced samples.

Parameters:
- DATA_BITS, 12, ADC result width; sample is [DATA_BITS-1:0].
- CFG_BITS, 6, width of the configuration word shifted out on adc_sdi.
- CLK_DIV, 2, clk cycles per SCLK half-period (>=1).
- CONV_HIGH, 2, clk cycles adc_convst is held high (>=1).
- CONV_WAIT, 80, clk cycles waited after CONVST falls, before the first SCLK.
- SAMPLE_PERIOD, 256, clk cycles between successive CONVST rising edges; must be >= CONV_HIGH+CONV_WAIT+2*CLK_DIV*DATA_BITS+2.

Ports:
- clk, in, 1, system clock; all logic on rising edge.
- reset_n, in, 1, asynchronous active-low reset.
- run, in, 1, level; enables periodic sampling.
- cfg, in, CFG_BITS, ADC config word; latched at frame start.
- adc_convst, out, 1, conversion start to ADC.
- adc_sclk, out, 1, serial clock to ADC; idles low.
- adc_sdi, out, 1, config data to ADC, MSB-first.
- adc_sdo, in, 1, result data from ADC, MSB-first.
- sample, out, DATA_BITS, last completed conversion result.
- sample_valid, out, 1, one-clk pulse when sample updates.
- busy, out, 1, high while a frame is in progress (any state except IDLE).
- overrun, out, 1, sticky; set when a period tick arrives while busy.

Behaviour:
- Reset: asynchronous, active-low. On assertion, immediately (mid-frame included): state=IDLE, period counter=0, adc_convst=0, adc_sclk=0, adc_sdi=0, sample=0, sample_valid=0, busy=0, overrun=0. No partial result is ever published.
- Period counter:
  - Counts 0..SAMPLE_PERIOD-1 while run=1, then wraps.
  - The tick is the cycle the counter equals 0 with run=1; the first tick therefore occurs on the first clk edge after run rises.
  - While run=0 the counter is held at 0.
- Tick handling: a tick in IDLE starts a frame. A tick while busy is ignored and sets overrun (cleared only by reset).
- States:
  - IDLE -> CONV on tick. The frame-start edge sets adc_convst=1, latches cfg into the SDI shift register, clears the RX shift register and sets busy=1.
  - CONV: adc_convst stays high for exactly CONV_HIGH cycles, then falls -> WAIT.
  - WAIT: CONV_WAIT cycles with adc_convst=0 and adc_sclk=0 -> SHIFT. adc_sdi presents cfg MSB from WAIT entry onward.
  - SHIFT: DATA_BITS SCLK periods. Each period is CLK_DIV cycles low, then CLK_DIV cycles high.
    - adc_sdo is captured on the clk edge that drives adc_sclk 0->1 and shifted into the RX register LSB (MSB arrives first).
    - adc_sdi advances to the next cfg bit on each 1->0 SCLK edge. After CFG_BITS bits, adc_sdi=0.
    - After the final high half-period, adc_sclk returns to 0 -> DONE.
  - DONE: one cycle. sample <= RX register, sample_valid=1 -> IDLE, busy=0.
- Latency: sample_valid is asserted exactly CONV_HIGH+CONV_WAIT+2*CLK_DIV*DATA_BITS+1 clk cycles after the adc_convst rising edge (131 with defaults).
- run deasserted mid-frame: the current frame completes normally and publishes its sample; no new frame starts; period counter goes to 0.
- sample holds its value between frames. sample_valid is never high for two consecutive cycles.
- cfg changes mid-frame have no effect until the next frame.

Test Plan:
- Basic capture: defaults. ADC model returns 0xA5C. run=1 -> adc_convst high 2 cycles; 12 SCLK rising edges; sample=0xA5C with one sample_valid pulse 131 cycles after CONVST rise; busy low afterwards.
- Rate/periodicity: run=1 for 1024 cycles with ADC returning 0x001,0x002,... -> CONVST rising edges exactly 256 cycles apart; 4 valid pulses carrying 0x001..0x004 in order; overrun=0.
- Config shift: cfg=6'b100010 -> adc_sdi reads 1,0,0,0,1,0 on successive SCLK rising edges, then 0 for the remaining 6 bits.
- Overrun: SAMPLE_PERIOD overridden to 100 (below frame length) -> overrun=1 after the second tick. Frames are never truncated: each valid is preceded by exactly 12 SCLK pulses.
- Reset mid-frame: assert reset_n=0 during SHIFT at bit 5 -> same cycle adc_sclk=0, adc_convst=0, sample=0, busy=0, no sample_valid. After release with run=1, the next frame captures the full 12 bits correctly.
- run drop and extremes: deassert run during WAIT -> that frame still yields valid; no further CONVST. ADC returning 0x000 and 0xFFF are captured exactly.
